// File: rtl/mod_reduce_34.sv
// Sequential modular reducer: accepts a DATA_W-bit value x and a modulus m over AXI-stream
// handshakes, and returns x mod m after one restoring shift-subtract step per bit of x.
module mod_reduce_34 #(
  parameter int DATA_W = 34,
  parameter int MOD_W  = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] input_tdata,
  input  logic              input_tvalid,
  output logic              input_tready,
  input  logic [MOD_W-1:0]  modulus,
  output logic [MOD_W-1:0]  output_tdata,
  output logic              output_tuser,
  output logic              output_tvalid,
  input  logic              output_tready
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [DATA_W-1:0]   x_r, x_s;
  logic [MOD_W-1:0]    m_r, m_s;
  logic [MOD_W:0]      rem_r, rem_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [MOD_W-1:0]    res_r, res_s;
  logic                err_r, err_s;
  logic [MOD_W:0]      step_s;

  // The remainder stays below m, so the shifted value fits in MOD_W+1 bits without loss.
  function automatic logic [MOD_W:0] reduce_step(input logic [MOD_W:0]   rem,
                                                  input logic             bit_in,
                                                  input logic [MOD_W-1:0] m);
    logic [MOD_W:0] t;
    t = {rem[MOD_W-1:0], bit_in};
    if (t >= {1'b0, m}) begin
      reduce_step = t - {1'b0, m};
    end else begin
      reduce_step = t;
    end
  endfunction

  // Next-state and datapath update for the single in-flight operation.
  always_comb begin
    state_s = state_r;
    x_s     = x_r;
    m_s     = m_r;
    rem_s   = rem_r;
    cnt_s   = cnt_r;
    res_s   = res_r;
    err_s   = err_r;
    step_s  = reduce_step(rem_r, x_r[cnt_r], m_r);
    case (state_r)
      IDLE: begin
        if (input_tvalid) begin
          if (modulus != {MOD_W{1'b0}}) begin
            x_s     = input_tdata;
            m_s     = modulus;
            rem_s   = {(MOD_W+1){1'b0}};
            cnt_s   = CNT_W'(DATA_W - 1);
            state_s = REDUCE;
          end else begin
            res_s   = {MOD_W{1'b0}};
            err_s   = 1'b1;
            state_s = DONE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      REDUCE: begin
        rem_s = step_s;
        if (cnt_r == {CNT_W{1'b0}}) begin
          res_s   = step_s[MOD_W-1:0];
          err_s   = 1'b0;
          state_s = DONE;
        end else begin
          cnt_s   = cnt_r - CNT_W'(1);
          state_s = REDUCE;
        end
      end
      DONE: begin
        if (output_tready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      x_r     <= {DATA_W{1'b0}};
      m_r     <= {MOD_W{1'b0}};
      rem_r   <= {(MOD_W+1){1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      res_r   <= {MOD_W{1'b0}};
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      x_r     <= x_s;
      m_r     <= m_s;
      rem_r   <= rem_s;
      cnt_r   <= cnt_s;
      res_r   <= res_s;
      err_r   <= err_s;
    end
  end

  // Ready is gated by reset so it drops immediately and is up before the first edge after release.
  assign input_tready  = rst & (state_r == IDLE);
  assign output_tvalid = (state_r == DONE);
  assign output_tdata  = res_r;
  assign output_tuser  = err_r;

endmodule

// File: tb/tb_mod_reduce_34.sv
// Self-checking bench for mod_reduce_34: directed vector table, backpressure and reset
// sequences, then randomized back-to-back operations against an x % m reference model.
module tb_mod_reduce_34;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [33:0] input_tdata = 34'd0;
  logic        input_tvalid = 1'b0;
  logic        input_tready;
  logic [16:0] modulus = 17'd0;
  logic [16:0] output_tdata;
  logic        output_tuser;
  logic        output_tvalid;
  logic        output_tready = 1'b0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [33:0] x;
    logic [16:0] m;
    logic [16:0] d;
    logic        u;
    int          lat;
  } vec_t;

  typedef struct {
    logic [33:0] x;
    logic [16:0] m;
    logic [16:0] d;
  } exp_t;

  mod_reduce_34 dut (
    .clk          (clk),
    .rst          (rst),
    .input_tdata  (input_tdata),
    .input_tvalid (input_tvalid),
    .input_tready (input_tready),
    .modulus      (modulus),
    .output_tdata (output_tdata),
    .output_tuser (output_tuser),
    .output_tvalid(output_tvalid),
    .output_tready(output_tready)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Presents x/m and returns just after the accepting rising edge.
  task automatic accept(input logic [33:0] x, input logic [16:0] m);
    int seen;
    seen = 0;
    @(negedge clk);
    input_tdata  = x;
    modulus      = m;
    input_tvalid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (input_tready) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    check("accept_ready", 64'(seen), 64'd1);
    @(posedge clk);
    #1;
    input_tvalid = 1'b0;
  endtask

  // Counts rising edges after the accept until output_tvalid is seen (-1 on timeout).
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (output_tvalid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    output_tready = 1'b1;
    accept(v.x, v.m);
    wait_valid(lat);
    check({tag, "_latency"}, 64'(lat), 64'(v.lat));
    check({tag, "_tdata"}, 64'(output_tdata), 64'(v.d));
    check({tag, "_tuser"}, 64'(output_tuser), 64'(v.u));
    @(posedge clk);
    #1;
    @(negedge clk);
    check({tag, "_ready_after"}, 64'(input_tready), 64'd1);
    check({tag, "_valid_after"}, 64'(output_tvalid), 64'd0);
  endtask

  vec_t vecs[7];

  initial begin
    int          lat;
    int          bad;
    int          sent;
    int          received;
    int          cyc;
    exp_t        q[$];
    exp_t        e;
    logic [33:0] rx;
    logic [16:0] rm;
    logic [63:0] ref_mod;

    vecs[0] = '{34'd1000000,       17'd65521,  17'd17185, 1'b0, 34};
    vecs[1] = '{34'h3_FFFF_FFFF,   17'd131071, 17'd0,     1'b0, 34};
    vecs[2] = '{34'd5,             17'd7,      17'd5,     1'b0, 34};
    vecs[3] = '{34'd12345,         17'd0,      17'd0,     1'b1, 0};
    vecs[4] = '{34'd10,            17'd3,      17'd1,     1'b0, 34};
    vecs[5] = '{34'd393220,        17'd131071, 17'd7,     1'b0, 34};
    vecs[6] = '{34'h2_0000_0000,   17'd1,      17'd0,     1'b0, 34};

    // Reset state, including the asynchronous zero before any clock edge.
    #2;
    check("reset_tready", 64'(input_tready), 64'd0);
    check("reset_tvalid", 64'(output_tvalid), 64'd0);
    check("reset_tdata", 64'(output_tdata), 64'd0);
    check("reset_tuser", 64'(output_tuser), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_tready", 64'(input_tready), 64'd1);

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: result must hold while new inputs and modulus churn.
    output_tready = 1'b0;
    accept(34'd1000000, 17'd65521);
    wait_valid(lat);
    check("bp_latency", 64'(lat), 64'd34);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (output_tdata !== 17'd17185 || output_tvalid !== 1'b1 || input_tready !== 1'b0 ||
          output_tuser !== 1'b0) begin
        bad++;
      end
      input_tvalid = 1'b1;
      input_tdata  = 34'($urandom);
      modulus      = 17'($urandom_range(1, 131071));
      @(negedge clk);
    end
    check("bp_hold_errors", 64'(bad), 64'd0);
    input_tdata   = 34'd5;
    modulus       = 17'd7;
    output_tready = 1'b1;
    @(posedge clk);
    #1;
    output_tready = 1'b0;
    @(negedge clk);
    check("bp_ready_after", 64'(input_tready), 64'd1);
    check("bp_valid_after", 64'(output_tvalid), 64'd0);
    check("bp_tdata_hold", 64'(output_tdata), 64'd17185);
    @(posedge clk);
    #1;
    input_tvalid  = 1'b0;
    output_tready = 1'b1;
    wait_valid(lat);
    check("bp_next_latency", 64'(lat), 64'd34);
    check("bp_next_tdata", 64'(output_tdata), 64'd5);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a reduction.
    accept(34'd1000000, 17'd65521);
    repeat (17) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_tready", 64'(input_tready), 64'd0);
    check("midrst_tvalid", 64'(output_tvalid), 64'd0);
    check("midrst_tdata", 64'(output_tdata), 64'd0);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ready_after", 64'(input_tready), 64'd1);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (output_tvalid !== 1'b0) bad++;
      @(negedge clk);
    end
    check("midrst_no_result", 64'(bad), 64'd0);
    run_vec(vecs[0], "after_rst");

    // Randomized back-to-back traffic against a queue of x % m expectations.
    sent = 0;
    received = 0;
    bad = 0;
    for (cyc = 0; cyc < 60000; cyc++) begin
      @(negedge clk);
      if (received == 1000) break;
      if (sent < 1000 && $urandom_range(0, 3) != 0) begin
        rx = {2'($urandom_range(0, 3)), 32'($urandom)};
        rm = ($urandom_range(0, 3) == 0) ? 17'($urandom_range(1, 15))
                                         : 17'($urandom_range(1, 131071));
        input_tvalid = 1'b1;
        input_tdata  = rx;
        modulus      = rm;
      end else begin
        input_tvalid = 1'b0;
        input_tdata  = 34'($urandom);
        modulus      = 17'($urandom);
      end
      output_tready = 1'($urandom_range(0, 1));
      if (input_tvalid && input_tready) begin
        ref_mod = {30'd0, input_tdata} % {47'd0, modulus};
        q.push_back('{input_tdata, modulus, 17'(ref_mod)});
        sent++;
      end
      if (output_tvalid && output_tready) begin
        received++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL rand_unexpected: got result %0d expected none", output_tdata);
        end else begin
          e = q.pop_front();
          checks++;
          if (output_tdata !== e.d || output_tuser !== 1'b0) begin
            failures++;
            $display("FAIL rand_result x=%0d m=%0d: got %0d/%0d expected %0d/0",
                     e.x, e.m, output_tdata, output_tuser, e.d);
          end
        end
      end
    end
    input_tvalid = 1'b0;
    check("rand_received", 64'(received), 64'd1000);
    check("rand_unexpected_results", 64'(bad), 64'd0);
    check("rand_queue_empty", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mod_reduce_34.md
MOD_REDUCE_34 -- requirements
Module: mod_reduce_34

Interface
REQ-001 SHALL have parameter DATA_W, default 34, meaning width of the product input stream.
REQ-002 SHALL have parameter MOD_W, default 17, meaning width of the modulus and of the result.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port input_tdata  input  DATA_W  product value x (AXI stream).
REQ-006 SHALL have port input_tvalid  input  1  x valid.
REQ-007 SHALL have port input_tready  output  1  block can accept x.
REQ-008 SHALL have port modulus  input  MOD_W  modulus m, sampled only on input transfer.
REQ-009 SHALL have port output_tdata  output  MOD_W  result x mod m (AXI stream).
REQ-010 SHALL have port output_tuser  output  1  error flag: m was zero.
REQ-011 SHALL have port output_tvalid  output  1  result valid.
REQ-012 SHALL have port output_tready  input  1  downstream accepts result.

Function
REQ-013 SHALL implement FSM states IDLE, REDUCE, DONE; only one operation in flight.
REQ-014 SHALL drive input_tready=1 only in IDLE; input transfer = input_tvalid & input_tready at a rising edge.
REQ-015 SHALL, on input transfer with m!=0: latch x and m, clear remainder r (MOD_W+1 bits), load bit counter to DATA_W-1, go to REDUCE.
REQ-016 SHALL, on input transfer with m==0: set result 0, output_tuser=1, go directly to DONE (output_tvalid high the next cycle).
REQ-017 SHALL, per REDUCE cycle, process x bit [counter] MSB-first: t = (r<<1)|x[counter]; r = (t>=m) ? t-m : t; decrement counter.
REQ-018 SHALL go REDUCE->DONE on the edge processing bit 0; output_tvalid rises exactly DATA_W cycles after the accepting edge (34 for default).
REQ-019 SHALL guarantee output_tdata < m and output_tdata == x mod m for every x < 2^DATA_W and m in 1..2^MOD_W-1; compare/subtract SHALL be MOD_W+1 bits wide, no truncation.
REQ-020 SHALL, in DONE, hold output_tvalid=1 with output_tdata and output_tuser stable until output_tvalid & output_tready at an edge.
REQ-021 SHALL go DONE->IDLE on output transfer; input_tready=1 the cycle after; throughput one result per DATA_W+2 cycles minimum.
REQ-022 SHALL ignore input_tdata, input_tvalid and modulus changes outside IDLE; latched m is used for the whole operation.
REQ-023 SHALL drive output_tvalid=0 in IDLE and REDUCE; output_tdata SHALL hold last result outside DONE.
REQ-024 SHALL ignore output_tready when output_tvalid=0.

Reset
REQ-025 SHALL, while rst=0, force state IDLE, r=0, counter=0, output_tdata=0, output_tuser=0, output_tvalid=0, input_tready=0, regardless of clk.
REQ-026 SHALL, on rst assertion mid-REDUCE or mid-DONE, abandon the operation with no output transfer; first edge after rst=1 finds IDLE with input_tready=1.

Verification
REQ-027 SHALL cover: x=1000000, m=65521, output_tready=1 -> output_tvalid 34 cycles after accept, tdata=17185, tuser=0.
REQ-028 SHALL cover: x=2^34-1, m=131071 -> tdata=0; x=5, m=7 -> tdata=5 (x<m passthrough).
REQ-029 SHALL cover: m=0, x=12345 -> output_tvalid next cycle, tdata=0, tuser=1; next op m=3, x=10 -> tdata=1, tuser=0.
REQ-030 SHALL cover: output_tready=0 for 10 cycles in DONE while input_tvalid=1 and modulus toggles -> tdata stable, input_tready=0, no new accept until handshake.
REQ-031 SHALL cover: rst=0 pulse between clk edges during REDUCE cycle 17 -> outputs zero immediately, no result emitted, next op x=1000000, m=65521 -> 17185.
REQ-032 SHALL cover: 1000 random (x, m!=0) back-to-back with random output_tready -> every result matches reference x mod m, order preserved, no drops or duplicates.
